// File: rtl/fp_pkg.sv
// Shared floating-point types and helpers for the Precision library.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: operand class enum, exception flag struct, divider FSM states,
//           bias / canonical qNaN / classify helpers for any format up to 64-bit fields.
package fp_pkg;

    typedef enum logic [2:0] {
        ZERO,
        NORMAL,
        INF,
        QNAN,
        SNAN
    } fp_class_t;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIV,
        ROUND,
        HOLD
    } div_state_t;

    function automatic int exp_bias(input int exp_bits);
        return (1 << (exp_bits - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
    // Returned wide; callers cast to their word width.
    function automatic logic [127:0] qnan(input int exp_bits, input int man_bits);
        logic [127:0] r;
        r = ((128'd1 << exp_bits) - 128'd1) << man_bits;
        r = r | (128'd1 << (man_bits - 1));
        return r;
    endfunction

    // Exponent zero classifies as ZERO: subnormals are flushed.
    function automatic fp_class_t classify(input logic [63:0] exp_f, input logic [63:0] man_f,
                                           input int exp_bits, input int man_bits);
        logic [63:0] exp_ones;
        exp_ones = (64'd1 << exp_bits) - 64'd1;
        if (exp_f == '0) begin
            return ZERO;
        end else if (exp_f != exp_ones) begin
            return NORMAL;
        end else if (man_f == '0) begin
            return INF;
        end else if (((man_f >> (man_bits - 1)) & 64'd1) != '0) begin
            return QNAN;
        end else begin
            return SNAN;
        end
    endfunction

endpackage

// File: rtl/fp_mant_div.sv
// Iterative unsigned restoring divider, one quotient bit per clock, MSB first.
// Latency: done pulses QBITS-1 cycles after the start cycle (first bit is taken on the start edge).
// Backpressure: none; quotient/sticky hold until the next start, start restarts at any time.
// Ports: clk, rst (sync, active-high), start, dividend/divisor (WIDTH, divisor != 0,
//        dividend < 2*divisor), done (1-cycle pulse), quotient (QBITS, MSB weight 2^0), sticky.
module fp_mant_div #(
    parameter int WIDTH = 11,
    parameter int QBITS = WIDTH + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [QBITS-1:0] quotient,
    output logic             sticky
);

    localparam int CW = $clog2(QBITS + 1);

    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [QBITS-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   cur_rem;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] cur_dsr;
    logic             ge;

    always_comb begin
        // On start the operands feed the step directly so no cycle is spent loading.
        cur_rem = start ? {1'b0, dividend} : rem_q;
        cur_dsr = start ? divisor : dsr_q;
        ge      = (cur_rem >= {1'b0, cur_dsr});
        diff    = ge ? (cur_rem - {1'b0, cur_dsr}) : cur_rem;

        rem_d  = rem_q;
        dsr_d  = dsr_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;

        if (start || (cnt_q != '0)) begin
            // diff < divisor, so dropping its MSB on the shift loses nothing.
            rem_d  = diff << 1;
            dsr_d  = cur_dsr;
            quo_d  = start ? QBITS'(ge) : {quo_q[QBITS-2:0], ge};
            cnt_d  = start ? CW'(QBITS - 1) : (cnt_q - CW'(1));
            done_d = (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            dsr_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;
    assign sticky   = (rem_q != '0);

endmodule

// File: rtl/fp_divide.sv
// Parametrised IEEE-754 divider c = a / b, round-to-nearest-even, flush-to-zero subnormals.
// Latency: out_valid rises MAN_BITS+5 cycles after the accept edge for every operand class.
// Backpressure: single op in flight; in_ready only in IDLE, result held in HOLD until out_ready.
// Ports: clk, rst (sync, active-high), in_valid/in_ready + a/b operands,
//        out_valid/out_ready + c quotient and flags {invalid, div_by_zero, overflow, underflow, inexact}.
module fp_divide
    import fp_pkg::*;
#(
    parameter int  EXP_BITS = 5,
    parameter int  MAN_BITS = 10,
    localparam int BITS     = 1 + EXP_BITS + MAN_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] c,
    output logic [4:0]      flags
);

    localparam int WIDTH = MAN_BITS + 1;   // mantissa with hidden bit
    localparam int QBITS = MAN_BITS + 3;   // result bits + normalisation bit + guard bit
    localparam int EW    = EXP_BITS + 2;   // signed working exponent, room for over/underflow
    localparam int BIAS  = exp_bias(EXP_BITS);
    localparam logic [EW-1:0]   EXP_MAX   = EW'((1 << EXP_BITS) - 1);
    localparam logic [BITS-1:0] QNAN_WORD = BITS'(qnan(EXP_BITS, MAN_BITS));

    div_state_t              state_q, state_d;
    logic [BITS-1:0]         a_q, a_d, b_q, b_d;
    logic [BITS-1:0]         c_q, c_d;
    logic [BITS-1:0]         spec_res_q, spec_res_d;
    fp_flags_t               flags_q, flags_d;
    fp_flags_t               spec_flags_q, spec_flags_d;
    logic                    sign_q, sign_d;
    logic                    special_q, special_d;
    logic signed [EW-1:0]    exp_q, exp_d;

    // Unpack
    logic [EXP_BITS-1:0]     ea, eb;
    logic [MAN_BITS-1:0]     fa, fb;
    fp_class_t               cls_a, cls_b;
    logic                    sign_u;
    logic signed [EW-1:0]    exp_u;
    logic                    spec_u;
    logic [BITS-1:0]         spec_res_u;
    fp_flags_t               spec_flags_u;
    logic [WIDTH-1:0]        ma, mb;

    // Mantissa divider
    logic                    div_start, div_done, div_sticky;
    logic [QBITS-1:0]        div_quo;

    // Round
    logic                    q_ge1, guard, stk, rnd_up, carry;
    logic [WIDTH-1:0]        mant;
    logic [WIDTH:0]          mant_r;
    logic [MAN_BITS-1:0]     frac;
    logic signed [EW-1:0]    exp_n;
    logic [BITS-1:0]         rnd_res;
    fp_flags_t               rnd_flags;

    always_comb begin
        ea     = a_q[BITS-2:MAN_BITS];
        eb     = b_q[BITS-2:MAN_BITS];
        fa     = a_q[MAN_BITS-1:0];
        fb     = b_q[MAN_BITS-1:0];
        cls_a  = classify(64'(ea), 64'(fa), EXP_BITS, MAN_BITS);
        cls_b  = classify(64'(eb), 64'(fb), EXP_BITS, MAN_BITS);
        sign_u = a_q[BITS-1] ^ b_q[BITS-1];
        exp_u  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + EW'(BIAS);
        // Hidden bit always set: specials bypass the quotient, and a nonzero divisor keeps the divider sane.
        ma     = {1'b1, fa};
        mb     = {1'b1, fb};

        spec_u       = 1'b1;
        spec_res_u   = '0;
        spec_flags_u = '0;
        if ((cls_a == QNAN) || (cls_a == SNAN) || (cls_b == QNAN) || (cls_b == SNAN)) begin
            spec_res_u           = QNAN_WORD;
            spec_flags_u.invalid = (cls_a == SNAN) || (cls_b == SNAN);
        end else if (((cls_a == ZERO) && (cls_b == ZERO)) || ((cls_a == INF) && (cls_b == INF))) begin
            spec_res_u           = QNAN_WORD;
            spec_flags_u.invalid = 1'b1;
        end else if ((cls_a == NORMAL) && (cls_b == ZERO)) begin
            spec_res_u               = {sign_u, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
            spec_flags_u.div_by_zero = 1'b1;
        end else if (cls_a == INF) begin
            spec_res_u = {sign_u, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
        end else if ((cls_b == INF) || (cls_a == ZERO)) begin
            spec_res_u = {sign_u, {(BITS-1){1'b0}}};
        end else begin
            spec_u = 1'b0;
        end
    end

    assign div_start = (state_q == UNPACK);

    fp_mant_div #(
        .WIDTH (WIDTH),
        .QBITS (QBITS)
    ) u_mant_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (ma),
        .divisor  (mb),
        .done     (div_done),
        .quotient (div_quo),
        .sticky   (div_sticky)
    );

    always_comb begin
        // Quotient MSB has weight 2^0; below 1 the quotient is renormalised one place left.
        q_ge1 = div_quo[QBITS-1];
        if (q_ge1) begin
            mant  = div_quo[QBITS-1:2];
            guard = div_quo[1];
            stk   = div_quo[0] | div_sticky;
        end else begin
            mant  = div_quo[QBITS-2:1];
            guard = div_quo[0];
            stk   = div_sticky;
        end
        rnd_up = guard & (stk | mant[0]);
        mant_r = {1'b0, mant} + {{WIDTH{1'b0}}, rnd_up};
        carry  = mant_r[WIDTH];
        // A rounding carry leaves 10.00..0; shifting right one place keeps the fraction zero.
        frac   = carry ? mant_r[MAN_BITS:1] : mant_r[MAN_BITS-1:0];
        exp_n  = exp_q - EW'(!q_ge1) + EW'(carry);

        rnd_res           = {sign_q, exp_n[EXP_BITS-1:0], frac};
        rnd_flags         = '0;
        rnd_flags.inexact = guard | stk;
        if (exp_n[EW-1] || (exp_n == '0)) begin
            rnd_res             = {sign_q, {(BITS-1){1'b0}}};
            rnd_flags.underflow = 1'b1;
            rnd_flags.inexact   = 1'b1;
        end else if ($unsigned(exp_n) >= EXP_MAX) begin
            rnd_res            = {sign_q, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
            rnd_flags.overflow = 1'b1;
            rnd_flags.inexact  = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        flags_d      = flags_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        special_d    = special_q;
        spec_res_d   = spec_res_q;
        spec_flags_d = spec_flags_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d       = sign_u;
                exp_d        = exp_u;
                special_d    = spec_u;
                spec_res_d   = spec_res_u;
                spec_flags_d = spec_flags_u;
                state_d      = DIV;
            end
            DIV: begin
                if (div_done) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                c_d     = special_q ? spec_res_q : rnd_res;
                flags_d = special_q ? spec_flags_q : rnd_flags;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            flags_q      <= '0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            special_q    <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            flags_q      <= flags_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            special_q    <= special_d;
            spec_res_q   <= spec_res_d;
            spec_flags_q <= spec_flags_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign c         = c_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_divide.sv
// Bench for fp_divide: half and single precision instances, scoreboard queue of expected results.
// Latency: checks exact accept-to-out_valid distance (15 half, 28 single).
// Backpressure: exercises out_ready low hold and a mid-operation synchronous reset.
module tb_fp_divide;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_c;
    logic [4:0]  h_flags;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_a, s_b, s_c;
    logic [4:0]  s_flags;

    fp_divide #(.EXP_BITS(5), .MAN_BITS(10)) u_half (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (h_in_valid),
        .in_ready  (h_in_ready),
        .a         (h_a),
        .b         (h_b),
        .out_valid (h_out_valid),
        .out_ready (h_out_ready),
        .c         (h_c),
        .flags     (h_flags)
    );

    fp_divide #(.EXP_BITS(8), .MAN_BITS(23)) u_single (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .a         (s_a),
        .b         (s_b),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .c         (s_c),
        .flags     (s_flags)
    );

    // Currently selected DUT view.
    logic        sel;
    logic        cur_in_ready, cur_out_valid;
    logic [31:0] cur_c;
    logic [4:0]  cur_flags;

    always_comb begin
        cur_in_ready  = sel ? s_in_ready  : h_in_ready;
        cur_out_valid = sel ? s_out_valid : h_out_valid;
        cur_c         = sel ? s_c         : {16'h0000, h_c};
        cur_flags     = sel ? s_flags     : h_flags;
    end

    typedef struct {
        logic [31:0] c;
        logic [4:0]  f;
    } exp_t;
    exp_t sb_q[$];

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic set_in(input bit sgl, input bit v, input logic [31:0] av, input logic [31:0] bv);
        if (sgl) begin
            s_in_valid = v;
            s_a        = av;
            s_b        = bv;
        end else begin
            h_in_valid = v;
            h_a        = av[15:0];
            h_b        = bv[15:0];
        end
    endtask

    task automatic set_out_ready(input bit sgl, input bit v);
        if (sgl) s_out_ready = v;
        else     h_out_ready = v;
    endtask

    task automatic do_op(input bit sgl, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ec, input logic [4:0] ef, input int hold);
        exp_t  e;
        exp_t  w;
        int    lat;
        bit    ok;
        string id;
        id  = $sformatf("%h/%h", av, bv);
        sel = sgl;
        e.c = ec;
        e.f = ef;
        sb_q.push_back(e);
        @(negedge clk);
        set_out_ready(sgl, hold == 0);
        set_in(sgl, 1'b1, av, bv);
        lat = 0;
        while (!cur_in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({"accept ", id}, cur_in_ready, 1);
        // Handshake completes on the next rising edge.
        @(negedge clk);
        lat = 0;
        set_in(sgl, 1'b0, '0, '0);
        chk({"busy in_ready ", id}, cur_in_ready, 0);
        while (!cur_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({"latency ", id}, lat, sgl ? 28 : 15);
        w = sb_q.pop_front();
        chk({"c ", id}, cur_c, w.c);
        chk({"flags ", id}, cur_flags, w.f);
        if (hold > 0) begin
            ok = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!cur_out_valid || cur_c !== w.c || cur_flags !== w.f || cur_in_ready)
                    ok = 1'b0;
            end
            chk({"hold stable ", id}, ok, 1);
            set_out_ready(sgl, 1'b1);
        end
        @(negedge clk);
        chk({"in_ready after ", id}, cur_in_ready, 1);
        chk({"out_valid after ", id}, cur_out_valid, 0);
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [4:0]  f;
    } hvec_t;

    localparam int NH = 17;
    hvec_t hv [NH] = '{
        '{16'h3C00, 16'h4000, 16'h3800, 5'b00000},  // 1/2
        '{16'h3C00, 16'h4200, 16'h3555, 5'b00001},  // 1/3
        '{16'h4500, 16'h4200, 16'h3EAB, 5'b00001},  // 5/3 rounds up
        '{16'hC200, 16'h3C00, 16'hC200, 5'b00000},  // -3/1
        '{16'h3C00, 16'h0000, 16'h7C00, 5'b01000},  // 1/0
        '{16'h3C00, 16'h8000, 16'hFC00, 5'b01000},  // 1/-0
        '{16'h0000, 16'h0000, 16'h7E00, 5'b10000},  // 0/0
        '{16'h7C00, 16'h7C00, 16'h7E00, 5'b10000},  // inf/inf
        '{16'hBC00, 16'h7C00, 16'h8000, 5'b00000},  // -1/inf
        '{16'h7C00, 16'h3C00, 16'h7C00, 5'b00000},  // inf/1
        '{16'h0000, 16'h4000, 16'h0000, 5'b00000},  // 0/2
        '{16'h0200, 16'h3C00, 16'h0000, 5'b00000},  // subnormal flushed to zero
        '{16'h7C01, 16'h3C00, 16'h7E00, 5'b10000},  // sNaN operand
        '{16'h7E00, 16'h3C00, 16'h7E00, 5'b00000},  // qNaN operand
        '{16'h3C00, 16'h7E00, 16'h7E00, 5'b00000},  // qNaN divisor
        '{16'h7BFF, 16'h1400, 16'h7C00, 5'b00101},  // overflow
        '{16'h0400, 16'h7BFF, 16'h0000, 5'b00011}   // underflow
    };

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        bit seen;
        sel         = 1'b0;
        rst         = 1'b1;
        h_in_valid  = 1'b0;
        h_a         = '0;
        h_b         = '0;
        h_out_ready = 1'b1;
        s_in_valid  = 1'b0;
        s_a         = '0;
        s_b         = '0;
        s_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset in_ready", h_in_ready, 1);
        chk("reset out_valid", h_out_valid, 0);
        chk("reset c", h_c, 16'h0000);
        chk("reset flags", h_flags, 5'b00000);
        chk("reset single in_ready", s_in_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < NH; i++) begin
            do_op(1'b0, {16'h0000, hv[i].a}, {16'h0000, hv[i].b}, {16'h0000, hv[i].c}, hv[i].f, 0);
        end

        do_op(1'b1, 32'h40490FDB, 32'h40000000, 32'h3FC90FDB, 5'b00000, 10);
        do_op(1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 0);

        // Reset in the middle of a divide: the result must never appear.
        sel = 1'b0;
        @(negedge clk);
        set_in(1'b0, 1'b1, 32'h3C00, 32'h4000);
        @(negedge clk);
        set_in(1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst in_ready", h_in_ready, 1);
        chk("rst out_valid", h_out_valid, 0);
        seen = 1'b0;
        lat  = 0;
        while (lat < 30) begin
            @(negedge clk);
            if (h_out_valid) seen = 1'b1;
            lat++;
        end
        chk("rst no stale result", seen, 0);
        do_op(1'b0, 32'h3C00, 32'h4000, 32'h3800, 5'b00000, 0);

        chk("scoreboard drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
